// File: rtl/ex_mem_pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline register: branch-type bit indices,
// MEM/WB control field offsets, the link register and the skid-buffer state encoding.
package ex_mem_pipe_pkg;

    localparam int BR_BEQ    = 0;
    localparam int BR_BNE    = 1;
    localparam int BR_BGEZ   = 2;
    localparam int BR_BGTZ   = 3;
    localparam int BR_BLTZ   = 4;
    localparam int BR_BLEZ   = 5;
    localparam int BR_BGEZAL = 6;
    localparam int BR_BLTZAL = 7;

    // Control word is packed MSB-first; bits [1:0] are spare.
    localparam int REGWRITE_BIT   = 11;
    localparam int MEMIOTOREG_BIT = 10;
    localparam int MFHI_BIT       = 9;
    localparam int MFLO_BIT       = 8;
    localparam int MTHI_BIT       = 7;
    localparam int MTLO_BIT       = 6;
    localparam int MEMWRITE_BIT   = 5;
    localparam int MEMSIGN_BIT    = 4;
    localparam int MEMWIDTH_MSB   = 3;
    localparam int MEMWIDTH_LSB   = 2;

    localparam int LINK_REG = 31;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_MAIN  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    function automatic logic branch_taken(
        input logic [7:0] br,
        input logic       z,
        input logic       p,
        input logic       n
    );
        return (br[BR_BEQ]    &  z)
             | (br[BR_BNE]    & ~z)
             | (br[BR_BGEZ]   & (p | z))
             | (br[BR_BGTZ]   &  p)
             | (br[BR_BLTZ]   &  n)
             | (br[BR_BLEZ]   & (n | z))
             | (br[BR_BGEZAL] & (p | z))
             | (br[BR_BLTZAL] &  n);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry in-order skid buffer (main + skid) with flush.
// Handshake: a word moves on an edge where valid && ready; o_in_ready depends only on state.
module pipe_skid_buf
    import ex_mem_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data,
    output skid_state_e  o_state
);

    skid_state_e r_state;
    skid_state_e w_next_state;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic w_accept;
    logic w_deliver;

    assign w_accept  = i_in_valid && o_in_ready;
    assign w_deliver = o_out_valid && i_out_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_flush) begin
            w_next_state = SKID_EMPTY;
        end else begin
            case (r_state)
                SKID_EMPTY: if (w_accept) w_next_state = SKID_MAIN;
                SKID_MAIN: begin
                    if (w_accept && !w_deliver)      w_next_state = SKID_FULL;
                    else if (!w_accept && w_deliver) w_next_state = SKID_EMPTY;
                end
                SKID_FULL:  if (w_deliver) w_next_state = SKID_MAIN;
                default:    w_next_state = SKID_EMPTY;
            endcase
        end
    end

    always_comb begin
        o_in_ready  = (r_state != SKID_FULL);
        o_out_valid = (r_state != SKID_EMPTY);
        o_state     = r_state;
    end

    // Empty-slot contents are don't-care; only the state register decides validity.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (!i_flush) begin
            if (r_state == SKID_FULL && w_deliver) begin
                r_main <= r_skid;
            end else if (w_accept && (r_state == SKID_EMPTY || w_deliver)) begin
                r_main <= i_in_data;
            end
            if (r_state == SKID_MAIN && w_accept && !w_deliver) begin
                r_skid <= i_in_data;
            end
        end
    end

    assign o_out_data = r_main;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage: elastic two-entry register for MEM/WB payload,
// branch resolution with a one-cycle redirect pulse, and a saturating stall counter.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int RADDR_W     = 5,
    parameter int CTRL_W      = 12,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic                   ex_zero,
    input  logic                   ex_positive,
    input  logic                   ex_negative,
    input  logic [7:0]             ex_br_type,
    input  logic [CTRL_W-1:0]      ex_ctrl,
    input  logic [DATA_W-1:0]      ex_add_result,
    input  logic [DATA_W-1:0]      ex_alu_result,
    input  logic [DATA_W-1:0]      ex_read_data_2,
    input  logic [RADDR_W-1:0]     ex_waddr,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [CTRL_W-1:0]      mem_ctrl,
    output logic [DATA_W-1:0]      mem_alu_result,
    output logic [DATA_W-1:0]      mem_data_in,
    output logic [RADDR_W-1:0]     mem_waddr,
    output logic                   if_branch_taken,
    output logic [DATA_W-1:0]      if_branch_pc,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int PAY_W = CTRL_W + 2 * DATA_W + RADDR_W;

    logic                   w_accept;
    logic                   w_link;
    logic                   w_taken;
    logic                   w_stalled;
    logic [CTRL_W-1:0]      w_ctrl;
    logic [RADDR_W-1:0]     w_waddr;
    logic [PAY_W-1:0]       w_in_payload;
    logic [PAY_W-1:0]       w_out_payload;
    skid_state_e            w_skid_state;
    logic                   r_br_taken;
    logic [DATA_W-1:0]      r_br_pc;
    logic [STALL_CNT_W-1:0] r_stall;

    assign w_accept = ex_valid && ex_ready;
    assign w_link   = ex_br_type[BR_BGEZAL] | ex_br_type[BR_BLTZAL];
    assign w_taken  = branch_taken(ex_br_type, ex_zero, ex_positive, ex_negative);

    // Linking branches always write the return address to the link register.
    always_comb begin
        w_ctrl  = ex_ctrl;
        w_waddr = ex_waddr;
        if (w_link) begin
            w_ctrl[REGWRITE_BIT] = 1'b1;
            w_waddr              = RADDR_W'(LINK_REG);
        end
    end

    assign w_in_payload = {w_ctrl, ex_alu_result, ex_read_data_2, w_waddr};

    pipe_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .i_clk       (clock),
        .i_rst_n     (reset),
        .i_flush     (flush),
        .i_in_valid  (ex_valid),
        .o_in_ready  (ex_ready),
        .i_in_data   (w_in_payload),
        .o_out_valid (mem_valid),
        .i_out_ready (mem_ready),
        .o_out_data  (w_out_payload),
        .o_state     (w_skid_state)
    );

    assign {mem_ctrl, mem_alu_result, mem_data_in, mem_waddr} = w_out_payload;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_br_taken <= 1'b0;
            r_br_pc    <= '0;
        end else begin
            r_br_taken <= !flush && w_accept && w_taken;
            if (!flush && w_accept && w_taken) begin
                r_br_pc <= ex_add_result;
            end
        end
    end

    assign if_branch_taken = r_br_taken;
    assign if_branch_pc    = r_br_pc;

    assign w_stalled = (w_skid_state != SKID_EMPTY) && !mem_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
        end else if (w_stalled && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: handshake, skid, branch pulse, link, flush,
// reset-mid-transfer and stall-counter saturation (narrow counter for speed).
module tb_ex_mem_pipe;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 12;
    localparam int SCW = 8;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          ex_valid;
    logic          ex_ready;
    logic          ex_zero;
    logic          ex_positive;
    logic          ex_negative;
    logic [7:0]    ex_br_type;
    logic [CW-1:0] ex_ctrl;
    logic [DW-1:0] ex_add_result;
    logic [DW-1:0] ex_alu_result;
    logic [DW-1:0] ex_read_data_2;
    logic [AW-1:0] ex_waddr;
    logic          mem_valid;
    logic          mem_ready;
    logic [CW-1:0] mem_ctrl;
    logic [DW-1:0] mem_alu_result;
    logic [DW-1:0] mem_data_in;
    logic [AW-1:0] mem_waddr;
    logic          if_branch_taken;
    logic [DW-1:0] if_branch_pc;
    logic [SCW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    ex_mem_pipe #(
        .DATA_W      (DW),
        .RADDR_W     (AW),
        .CTRL_W      (CW),
        .STALL_CNT_W (SCW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .ex_zero         (ex_zero),
        .ex_positive     (ex_positive),
        .ex_negative     (ex_negative),
        .ex_br_type      (ex_br_type),
        .ex_ctrl         (ex_ctrl),
        .ex_add_result   (ex_add_result),
        .ex_alu_result   (ex_alu_result),
        .ex_read_data_2  (ex_read_data_2),
        .ex_waddr        (ex_waddr),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_ctrl        (mem_ctrl),
        .mem_alu_result  (mem_alu_result),
        .mem_data_in     (mem_data_in),
        .mem_waddr       (mem_waddr),
        .if_branch_taken (if_branch_taken),
        .if_branch_pc    (if_branch_pc),
        .stall_cycles    (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
        ex_zero = 1'b0; ex_positive = 1'b0; ex_negative = 1'b0; ex_br_type = 8'h00;
        ex_ctrl = '0; ex_add_result = '0; ex_alu_result = '0; ex_read_data_2 = '0; ex_waddr = '0;

        // Reset state
        step(); step();
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_br_taken", if_branch_taken, 0);
        chk("rst_br_pc", if_branch_pc, 0);
        chk("rst_mem_ctrl", mem_ctrl, 0);
        chk("rst_mem_alu", mem_alu_result, 0);
        chk("rst_mem_data", mem_data_in, 0);
        chk("rst_mem_waddr", mem_waddr, 0);
        chk("rst_stall", stall_cycles, 0);
        reset = 1'b1;

        // Single transfer, latency 1
        mem_ready = 1'b1; ex_valid = 1'b1; ex_alu_result = 32'h10; ex_waddr = 5'd3;
        ex_read_data_2 = 32'hCAFE;
        step();
        chk("basic_valid", mem_valid, 1);
        chk("basic_alu", mem_alu_result, 32'h10);
        chk("basic_waddr", mem_waddr, 3);
        chk("basic_data", mem_data_in, 32'hCAFE);
        ex_valid = 1'b0;
        step();
        chk("basic_drain", mem_valid, 0);

        // Back-to-back into a stalled stage: A in main, B in skid
        mem_ready = 1'b0; ex_valid = 1'b1; ex_alu_result = 32'h1; ex_waddr = 5'd1;
        step();
        chk("skid_a_ready", ex_ready, 1);
        chk("skid_a_alu", mem_alu_result, 32'h1);
        ex_alu_result = 32'h2; ex_waddr = 5'd2;
        step();
        chk("skid_b_ready", ex_ready, 0);
        chk("skid_hold_alu", mem_alu_result, 32'h1);
        ex_valid = 1'b0;
        step();
        chk("skid_hold2_alu", mem_alu_result, 32'h1);
        chk("skid_hold_waddr", mem_waddr, 1);
        chk("skid_stall_cnt", stall_cycles, 2);
        mem_ready = 1'b1;
        step();
        chk("skid_b_valid", mem_valid, 1);
        chk("skid_b_alu", mem_alu_result, 32'h2);
        chk("skid_b_waddr", mem_waddr, 2);
        chk("skid_ready_back", ex_ready, 1);
        step();
        chk("skid_empty", mem_valid, 0);

        // Beq taken, then Bne not taken
        ex_valid = 1'b1; ex_br_type = 8'h01; ex_zero = 1'b1; ex_add_result = 32'h400;
        step();
        chk("beq_pulse", if_branch_taken, 1);
        chk("beq_pc", if_branch_pc, 32'h400);
        ex_valid = 1'b0; ex_br_type = 8'h00;
        step();
        chk("beq_pulse_end", if_branch_taken, 0);
        chk("beq_pc_hold", if_branch_pc, 32'h400);
        ex_valid = 1'b1; ex_br_type = 8'h02; ex_add_result = 32'h800;
        step();
        chk("bne_no_pulse", if_branch_taken, 0);
        chk("bne_pc_hold", if_branch_pc, 32'h400);
        ex_valid = 1'b0; ex_br_type = 8'h00; ex_zero = 1'b0;
        step();

        // Bltzal not taken still links; Bgezal taken links and pulses
        ex_valid = 1'b1; ex_br_type = 8'h80; ex_positive = 1'b1; ex_negative = 1'b0;
        ex_waddr = 5'd7; ex_ctrl = 12'h000; ex_add_result = 32'h900;
        step();
        chk("bltzal_waddr", mem_waddr, 31);
        chk("bltzal_regwrite", mem_ctrl[11], 1);
        chk("bltzal_no_pulse", if_branch_taken, 0);
        ex_br_type = 8'h40; ex_ctrl = 12'h020; ex_add_result = 32'h123;
        step();
        chk("bgezal_pulse", if_branch_taken, 1);
        chk("bgezal_pc", if_branch_pc, 32'h123);
        chk("bgezal_ctrl", mem_ctrl, 12'h820);
        chk("bgezal_waddr", mem_waddr, 31);
        ex_valid = 1'b0; ex_br_type = 8'h00; ex_positive = 1'b0; ex_ctrl = '0;
        step();
        chk("link_drain", mem_valid, 0);

        // Flush with both slots full and ex_valid high
        mem_ready = 1'b0; ex_valid = 1'b1; ex_alu_result = 32'hA; ex_waddr = 5'd4;
        step();
        ex_alu_result = 32'hB;
        step();
        chk("flush_pre_full", ex_ready, 0);
        flush = 1'b1;
        step();
        flush = 1'b0; ex_valid = 1'b0;
        chk("flush_valid", mem_valid, 0);
        chk("flush_ready", ex_ready, 1);
        chk("flush_stall_cnt", stall_cycles, 4);
        mem_ready = 1'b1;
        step();
        chk("flush_nothing", mem_valid, 0);

        // Flush discards a simultaneous taken-branch accept from empty
        ex_valid = 1'b1; ex_br_type = 8'h01; ex_zero = 1'b1; ex_add_result = 32'h555; flush = 1'b1;
        step();
        flush = 1'b0; ex_valid = 1'b0; ex_br_type = 8'h00; ex_zero = 1'b0;
        chk("flush_br_pulse", if_branch_taken, 0);
        chk("flush_br_pc", if_branch_pc, 32'h123);
        chk("flush_br_valid", mem_valid, 0);

        // Reset asserted mid-transfer
        mem_ready = 1'b0; ex_valid = 1'b1; ex_alu_result = 32'h77;
        step();
        ex_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_valid", mem_valid, 0);
        chk("midrst_ready", ex_ready, 1);
        chk("midrst_stall", stall_cycles, 0);
        chk("midrst_alu", mem_alu_result, 0);
        @(negedge clock);
        reset = 1'b1;
        mem_ready = 1'b1;
        step();
        chk("midrst_no_deliver", mem_valid, 0);

        // Stall counter saturation
        mem_ready = 1'b0; ex_valid = 1'b1; ex_alu_result = 32'h99;
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < (1 << SCW) + 5; i++) step();
        chk("stall_sat", stall_cycles, 8'hFF);
        chk("stall_hold_alu", mem_alu_result, 32'h99);
        mem_ready = 1'b1;
        step();
        chk("stall_sat_stay", stall_cycles, 8'hFF);
        chk("stall_drain", mem_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
